dma_copy_engine: RTL and testbench

Word-granular memory-to-memory copy engine that acts as an initiator on the single-cycle data bus (rd/wr/addr/wdata/rdata) served by the data-memory/peripheral responder. It lets software or a test harness move a block of 32-bit words between data memory and memory-mapped peripheral registers (e.g. 0x40000000–0x40000014) without the CPU issuing every load and store. It sits beside the CPU's data port and reaches the responder through the bus mux; an arbiter outside this block grants the bus while `busy` is high.

---
 rtl/dma_copy_pkg.sv | 9 +
 rtl/dma_copy_engine_if.sv | 10 +
 rtl/dma_copy_ptr.sv | 16 +
 rtl/dma_copy_engine.sv | 66 ++++++
 tb/tb_dma_copy_engine.sv | 119 +++++++++++
 5 files changed

// File: rtl/dma_copy_pkg.sv
// dma_copy_pkg: shared states, word size and address alignment for the copy engine
package dma_copy_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [31:0] ALIGN_MASK = ~(WORD_BYTES - 32'd1);
  function automatic logic [31:0] align(input logic [31:0] a);
    return a & ALIGN_MASK;
  endfunction
endpackage

// File: rtl/dma_copy_engine_if.sv
// dma_copy_engine_if: single-cycle data bus between the copy engine and the memory responder
interface dma_copy_engine_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master (output rd, wr, addr, wdata, input rdata);
  modport slave (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/dma_copy_ptr.sv
// dma_copy_ptr: word-aligned address register with load and wrapping increment-by-4
module dma_copy_ptr
  import dma_copy_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        inc,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (load) q <= align(d);
    else if (inc) q <= q + WORD_BYTES;
endmodule

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: word memory-to-memory copy, one read and one write per word
// Completion interrupt is built only when DMA_COPY_IRQ_EN is defined.
module dma_copy_engine
  import dma_copy_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        src,
  input  logic [31:0]        dst,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic               done,
  output logic               irq,
  input  logic               irq_clr,
  dma_copy_engine_if.master  bus
);
  state_t st, nxt;
  logic [LEN_W-1:0] remaining;
  logic [31:0] data_buf, src_ptr, dst_ptr;
  logic accept;
  assign accept = st == IDLE && start;
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:  nxt = accept ? (len != '0 ? READ : DONE) : IDLE;
      READ:  nxt = abort ? IDLE : WRITE;
      WRITE: nxt = abort ? IDLE : (remaining == LEN_W'(1) ? DONE : READ);
      DONE:  nxt = IDLE;
    endcase
  end
  assign busy = st == READ || st == WRITE;
  assign done = st == DONE;
  assign bus.rd = st == READ;
  assign bus.wr = st == WRITE;
  assign bus.addr = bus.rd ? src_ptr : bus.wr ? dst_ptr : '0;
  assign bus.wdata = bus.wr ? data_buf : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      remaining <= '0;
      data_buf <= '0;
    end else begin
      if (accept) remaining <= len;
      else if (st == WRITE) remaining <= remaining - LEN_W'(1);
      if (st == READ) data_buf <= bus.rdata;
    end
  dma_copy_ptr u_src (.clk(clk), .reset(reset), .load(accept), .inc(st == READ), .d(src), .q(src_ptr));
  dma_copy_ptr u_dst (.clk(clk), .reset(reset), .load(accept), .inc(st == WRITE), .d(dst), .q(dst_ptr));
`ifdef DMA_COPY_IRQ_EN
  // DONE always exits to IDLE, so setting from DONE marks the DONE->IDLE edge; set beats clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) irq <= 1'b0;
    else if (st == DONE) irq <= 1'b1;
    else if (irq_clr || accept) irq <= 1'b0;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: scoreboard bench checking bus trace, cycle timing, abort, reset and irq
module tb_dma_copy_engine;
  import dma_copy_pkg::*;
`ifdef DMA_COPY_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif
  typedef struct {logic w; logic [31:0] a; logic [31:0] d;} ev_t;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, irq_clr = 1'b0;
  logic [31:0] src = '0, dst = '0;
  logic [15:0] len = '0;
  logic busy, done, irq;
  int checks = 0, errors = 0;
  ev_t sbq[$];
  dma_copy_engine_if bus();
  dma_copy_engine #(.LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .irq(irq), .irq_clr(irq_clr), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction
  assign bus.rdata = bus.rd ? mem_val(bus.addr) : '0;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic push_word(input logic [31:0] s, input logic [31:0] d, input int i);
    logic [31:0] ra;
    ra = align(s) + 32'(4 * i);
    sbq.push_back('{1'b0, ra, 32'h0});
    sbq.push_back('{1'b1, align(d) + 32'(4 * i), mem_val(ra)});
  endtask
  always @(negedge clk)
    if (reset && (bus.rd || bus.wr)) begin
      ev_t e;
      check("rd_wr_excl", 64'(bus.rd & bus.wr), 64'h0);
      if (sbq.size() == 0) check("sb_unexpected", 64'(sbq.size()), 64'h1);
      else begin
        e = sbq.pop_front();
        check("bus_kind", 64'(bus.wr), 64'(e.w));
        check("bus_addr", 64'(bus.addr), 64'(e.a));
        if (e.w) check("bus_wdata", 64'(bus.wdata), 64'(e.d));
      end
    end
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                     input int abort_at, input int spur_at);
    int words, last;
    bit ab, eb, ed;
    ab = abort_at > 0;
    words = ab ? abort_at / 2 : int'(n);
    last = ab ? abort_at + 2 : 2 * int'(n) + 2;
    for (int i = 0; i < words; i++) push_word(s, d, i);
    @(negedge clk);
    src = s; dst = d; len = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      eb = ab ? (k <= abort_at) : (k <= 2 * int'(n));
      ed = !ab && k == 2 * int'(n) + 1;
      check($sformatf("busy_c%0d", k), 64'(busy), 64'(eb));
      check($sformatf("done_c%0d", k), 64'(done), 64'(ed));
      if (!eb) check($sformatf("idle_bus_c%0d", k), {bus.addr, bus.wdata}, 64'h0);
      if (k == 1 || k == last) check($sformatf("irq_c%0d", k), 64'(irq), 64'(k == last && !ab && IRQ_EN));
      if (k == abort_at || k == spur_at) begin
        abort = k == abort_at;
        if (k == spur_at) begin start = 1'b1; src = 32'hDEAD_0000; len = 16'd1; end
        @(posedge clk);
        #1 abort = 1'b0; start = 1'b0;
      end
    end
    check("sb_drained", 64'(sbq.size()), 64'h0);
  endtask
  initial begin
    #12;
    check("rst_ctrl", {busy, done, irq, bus.rd, bus.wr}, 64'h0);
    check("rst_bus", {bus.addr, bus.wdata}, 64'h0);
    reset = 1'b1;
    run(32'h100, 32'h200, 16'd3, 0, 0);
    run(32'h300, 32'h400, 16'd0, 0, 0);
    @(negedge clk);
    check("irq_hold", 64'(irq), 64'(IRQ_EN));
    irq_clr = 1'b1;
    @(posedge clk);
    #1 irq_clr = 1'b0;
    @(negedge clk);
    check("irq_cleared", 64'(irq), 64'h0);
    run(32'h500, 32'h600, 16'd4, 4, 0);
    run(32'h4000_0000, 32'h700, 16'd2, 0, 0);
    run(32'hFFFF_FFFE, 32'h4000_0004, 16'd2, 0, 0);
    run(32'h800, 32'h900, 16'd3, 0, 3);
    push_word(32'hA00, 32'hB00, 0);
    sbq.push_back('{1'b0, 32'hA04, 32'h0});
    @(negedge clk);
    src = 32'hA00; dst = 32'hB00; len = 16'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_async_ctrl", {busy, done, irq, bus.rd, bus.wr}, 64'h0);
    check("rst_async_bus", {bus.addr, bus.wdata}, 64'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_idle_%0d", k), {busy, done, bus.rd, bus.wr}, 64'h0);
    end
    check("rst_sb_drained", 64'(sbq.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
